// File: rtl/bj_pkg.sv
// rtl/bj_pkg.sv - shared types and helpers for branch/jump resolution
// Contents: bj_op_t operation encoding, ctr_t 2-bit BHT counter,
//   counter constants, bj_is_cond, bj_taken, ctr_next.
package bj_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_JAL  = 4'd1,
    OP_JALR = 4'd2,
    OP_BEQ  = 4'd3,
    OP_BNE  = 4'd4,
    OP_BLT  = 4'd5,
    OP_BGE  = 4'd6,
    OP_BLTU = 4'd7,
    OP_BGEU = 4'd8
  } bj_op_t;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  function automatic logic bj_is_cond(bj_op_t op);
    return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
  endfunction

  // The ALU flag is the "compare true" bit of the base condition
  // (equal / less-than); BNE, BGE and BGEU are its complements.
  function automatic logic bj_taken(bj_op_t op, logic flag);
    case (op)
      OP_JAL, OP_JALR:          return 1'b1;
      OP_BEQ, OP_BLT, OP_BLTU:  return flag;
      OP_BNE, OP_BGE, OP_BGEU:  return ~flag;
      default:                  return 1'b0;
    endcase
  endfunction

  function automatic ctr_t ctr_next(ctr_t ctr, logic taken);
    if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bj_bht.sv
// rtl/bj_bht.sv - bimodal table of 2-bit saturating counters
// Ports: clk, rst (sync, active-high); rd_idx -> rd_ctr combinational read;
//   wr_en/wr_idx/wr_taken train one counter at the clock edge.
module bj_bht
  import bj_pkg::*;
#(
  parameter int   DEPTH    = 64,
  parameter ctr_t CTR_INIT = CTR_WNT,
  localparam int  IW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_idx,
  output ctr_t          rd_ctr,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic          wr_taken
);

  ctr_t mem [DEPTH];

  // No write bypass: a read of the index being trained sees the old value.
  assign rd_ctr = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= CTR_INIT;
    end else if (wr_en) begin
      mem[wr_idx] <= ctr_next(mem[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/bj_resolve.sv
// rtl/bj_resolve.sv - execute-stage branch/jump resolution with redirect and drain
// Optional feature macro: BJ_MISALIGN_EXC_EN (misaligned-target exception).
// Inputs: clk, rst, in_valid, op, stall, pc, data1, imm, flag, pred_taken,
//   pred_pc, fetch_pc.
// Outputs: fetch_pred_taken, redirect_en, redirect_pc, flushing,
//   mispredict_cnt, exc_valid, exc_tval.
module bj_resolve
  import bj_pkg::*;
#(
  parameter int         XLEN         = 64,
  parameter int         BHT_DEPTH    = 64,
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [1:0] CTR_INIT     = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [3:0]      op,
  input  logic            stall,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] imm,
  input  logic            flag,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_pc,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            fetch_pred_taken,
  output logic            redirect_en,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flushing,
  output logic [31:0]     mispredict_cnt,
  output logic            exc_valid,
  output logic [XLEN-1:0] exc_tval
);

  localparam int IW = $clog2(BHT_DEPTH);
  localparam int DW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  bj_op_t          op_e;
  logic            resolve;
  logic            taken;
  logic            cond;
  logic            mispredict;
  logic            take_exc;
  logic            redirect_fire;
  logic            drain_load;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] actual;
  logic [DW-1:0]   drain_cnt;
  ctr_t            fetch_ctr;
  logic            unused_fetch_bits;

  assign op_e     = bj_op_t'(op);
  assign flushing = (drain_cnt != '0);

  always_comb begin
    jalr_sum   = data1 + imm;
    taken      = bj_taken(op_e, flag);
    cond       = bj_is_cond(op_e);
    target     = (op_e == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc + imm;
    actual     = taken ? target : pc + XLEN'(4);
    // A correctly predicted not-taken branch does not care what pred_pc holds.
    if (cond) mispredict = (pred_taken != taken) | (taken & (pred_pc != target));
    else      mispredict = ~pred_taken | (pred_pc != target);
    resolve    = in_valid & ~stall & ~flushing & (op_e != OP_NONE);
  end

`ifdef BJ_MISALIGN_EXC_EN
  assign take_exc = resolve & taken & target[1];
`else
  assign take_exc = 1'b0;
`endif

  // An exception replaces the redirect but still drains the wrong path.
  assign redirect_fire = resolve & mispredict & ~take_exc;
  assign drain_load    = redirect_fire | take_exc;

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_en    <= 1'b0;
      redirect_pc    <= '0;
      mispredict_cnt <= '0;
      drain_cnt      <= '0;
    end else begin
      redirect_en <= redirect_fire;
      if (redirect_fire) begin
        redirect_pc    <= actual;
        mispredict_cnt <= mispredict_cnt + 32'd1;
      end
      if (drain_load) drain_cnt <= DW'(FLUSH_CYCLES);
      else if (flushing && !stall) drain_cnt <= drain_cnt - DW'(1);
    end
  end

`ifdef BJ_MISALIGN_EXC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_valid <= 1'b0;
      exc_tval  <= '0;
    end else begin
      exc_valid <= take_exc;
      if (take_exc) exc_tval <= target;
    end
  end
`else
  assign exc_valid = 1'b0;
  assign exc_tval  = '0;
`endif

  bj_bht #(
    .DEPTH   (BHT_DEPTH),
    .CTR_INIT(CTR_INIT)
  ) u_bht (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (fetch_pc[IW+1:2]),
    .rd_ctr  (fetch_ctr),
    .wr_en   (resolve & cond),
    .wr_idx  (pc[IW+1:2]),
    .wr_taken(taken)
  );

  assign fetch_pred_taken  = fetch_ctr[1];
  assign unused_fetch_bits = ^{fetch_pc[XLEN-1:IW+2], fetch_pc[1:0], fetch_ctr[0]};

endmodule

// File: tb/tb_bj_resolve.sv
// tb/tb_bj_resolve.sv - directed self-checking bench for bj_resolve
module tb_bj_resolve;
  import bj_pkg::*;

  localparam int XLEN = 64;
`ifdef BJ_MISALIGN_EXC_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [3:0]      op = 4'd0;
  logic            stall = 1'b0;
  logic [XLEN-1:0] pc = '0;
  logic [XLEN-1:0] data1 = '0;
  logic [XLEN-1:0] imm = '0;
  logic            flag = 1'b0;
  logic            pred_taken = 1'b0;
  logic [XLEN-1:0] pred_pc = '0;
  logic [XLEN-1:0] fetch_pc = '0;
  logic            fetch_pred_taken;
  logic            redirect_en;
  logic [XLEN-1:0] redirect_pc;
  logic            flushing;
  logic [31:0]     mispredict_cnt;
  logic            exc_valid;
  logic [XLEN-1:0] exc_tval;

  int total = 0;
  int bad   = 0;

  bj_resolve #(
    .XLEN(XLEN), .BHT_DEPTH(64), .FLUSH_CYCLES(2), .CTR_INIT(2'b01)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .stall(stall),
    .pc(pc), .data1(data1), .imm(imm), .flag(flag), .pred_taken(pred_taken),
    .pred_pc(pred_pc), .fetch_pc(fetch_pc), .fetch_pred_taken(fetch_pred_taken),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .flushing(flushing),
    .mispredict_cnt(mispredict_cnt), .exc_valid(exc_valid), .exc_tval(exc_tval)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bj_op_t o, input logic [63:0] p, input logic [63:0] d1,
                       input logic [63:0] im, input logic f, input logic pt,
                       input logic [63:0] pp);
    in_valid   = 1'b1;
    op         = o;
    pc         = p;
    data1      = d1;
    imm        = im;
    flag       = f;
    pred_taken = pt;
    pred_pc    = pp;
  endtask

  initial begin
    fetch_pc = 64'h1000;
    tick();
    tick();
    check("rst_redirect_en", redirect_en, 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_flushing", flushing, 0);
    check("rst_cnt", mispredict_cnt, 0);
    check("rst_exc_valid", exc_valid, 0);
    check("rst_exc_tval", exc_tval, 0);
    check("rst_fetch_pred", fetch_pred_taken, 0);
    rst = 1'b0;

    // BNE not taken, predicted not taken: counter idx0 01->00
    issue(OP_BNE, 64'h1000, 0, 64'h40, 1'b1, 1'b0, 64'h1004);
    tick();
    check("bne_redirect", redirect_en, 0);
    check("bne_cnt", mispredict_cnt, 0);
    check("bne_flushing", flushing, 0);

    // BEQ taken, predicted not taken: redirect to 0x1040; counter 00->01
    issue(OP_BEQ, 64'h1000, 0, 64'h40, 1'b1, 1'b0, 64'h1004);
    tick();
    in_valid = 1'b0;
    check("beq_redirect", redirect_en, 1);
    check("beq_redirect_pc", redirect_pc, 64'h1040);
    check("beq_cnt", mispredict_cnt, 1);
    check("beq_flush0", flushing, 1);
    check("beq_bht", fetch_pred_taken, 0);
    tick();
    check("beq_pulse_end", redirect_en, 0);
    check("beq_flush1", flushing, 1);
    tick();
    check("beq_flush_done", flushing, 0);

    // JALR correctly predicted: target (0x2003+4)&~1 = 0x2006
    issue(OP_JALR, 64'h1f00, 64'h2003, 64'h4, 1'b0, 1'b1, 64'h2006);
    tick();
    in_valid = 1'b0;
    check("jalr_ok_redirect", redirect_en, 0);
    check("jalr_ok_cnt", mispredict_cnt, 1);
    check("jalr_ok_exc", exc_valid, EXC_ON);
    check("jalr_ok_tval", exc_tval, EXC_ON ? 64'h2006 : 64'h0);
    tick(); tick(); tick();
    check("jalr_ok_idle", flushing, 0);

    // JALR with wrong predicted target
    issue(OP_JALR, 64'h1f00, 64'h2003, 64'h4, 1'b0, 1'b1, 64'h2008);
    tick();
    in_valid = 1'b0;
    check("jalr_mis_redirect", redirect_en, !EXC_ON);
    check("jalr_mis_pc", redirect_pc, EXC_ON ? 64'h1040 : 64'h2006);
    check("jalr_mis_cnt", mispredict_cnt, EXC_ON ? 1 : 2);
    tick(); tick(); tick();

    // BGE taken mispredict, then a mispredicting op during the drain with one stall
    issue(OP_BGE, 64'h3010, 0, 64'h100, 1'b0, 1'b0, 64'h3014);
    tick();
    check("bge_redirect", redirect_en, 1);
    check("bge_pc", redirect_pc, 64'h3110);
    check("bge_cnt", mispredict_cnt, EXC_ON ? 2 : 3);
    check("drain_f0", flushing, 1);
    issue(OP_BEQ, 64'h1000, 0, 64'h40, 1'b1, 1'b0, 64'h1004);
    stall = 1'b1;
    tick();
    stall = 1'b0;
    check("drain_f1", flushing, 1);
    check("drain_r1", redirect_en, 0);
    tick();
    in_valid = 1'b0;
    check("drain_f2", flushing, 1);
    check("drain_r2", redirect_en, 0);
    tick();
    check("drain_f3", flushing, 0);
    check("drain_r3", redirect_en, 0);
    check("drain_cnt", mispredict_cnt, EXC_ON ? 2 : 3);
    check("drain_no_train", fetch_pred_taken, 0);

    // BLT taken three times at 0x1008: 01->10->11->11, then one not-taken -> 10
    fetch_pc = 64'h1008;
    issue(OP_BLT, 64'h1008, 0, 64'h20, 1'b1, 1'b1, 64'h1028);
    #1;
    check("blt_old_read", fetch_pred_taken, 0);
    tick();
    check("blt_t1", fetch_pred_taken, 1);
    check("blt_t1_redirect", redirect_en, 0);
    tick();
    check("blt_t2", fetch_pred_taken, 1);
    tick();
    check("blt_t3_sat", fetch_pred_taken, 1);
    issue(OP_BLT, 64'h1008, 0, 64'h20, 1'b0, 1'b0, 64'h100c);
    tick();
    in_valid = 1'b0;
    check("blt_nt", fetch_pred_taken, 1);
    check("blt_nt_redirect", redirect_en, 0);

    // Reset in the middle of a drain
    issue(OP_BEQ, 64'h1000, 0, 64'h40, 1'b1, 1'b0, 64'h1004);
    tick();
    in_valid = 1'b0;
    check("pre_rst_flush", flushing, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_flush", flushing, 0);
    check("rst2_redirect", redirect_en, 0);
    check("rst2_cnt", mispredict_cnt, 0);
    check("rst2_bht", fetch_pred_taken, 0);
    issue(OP_BLT, 64'h1008, 0, 64'h20, 1'b1, 1'b1, 64'h1028);
    tick();
    in_valid = 1'b0;
    check("rst2_bht_init", fetch_pred_taken, 1);

    // JAL to 0x102 (target bit 1 set)
    issue(OP_JAL, 64'h100, 0, 64'h2, 1'b0, 1'b0, 64'h0);
    tick();
    in_valid = 1'b0;
    check("jal_exc_valid", exc_valid, EXC_ON);
    check("jal_exc_tval", exc_tval, EXC_ON ? 64'h102 : 64'h0);
    check("jal_redirect", redirect_en, !EXC_ON);
    check("jal_redirect_pc", redirect_pc, EXC_ON ? 64'h0 : 64'h102);
    check("jal_cnt", mispredict_cnt, EXC_ON ? 0 : 1);
    check("jal_flush", flushing, 1);
    tick();
    check("jal_exc_end", exc_valid, 0);
    check("jal_redirect_end", redirect_en, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bj_resolve.md
Name: bj_resolve

Overview:
- Parametrised branch/jump resolution unit for the execute stage.
- Computes branch direction and target from the ALU compare flag, and checks them against the fetch-stage prediction.
- On a mispredict it issues a registered one-cycle redirect, then masks wrong-path instructions for a configurable drain window.
- Owns a bimodal branch history table (BHT) of 2-bit saturating counters; fetch reads it and resolved conditional branches train it.

Parameters:
- XLEN, 64, datapath and PC width.
- BHT_DEPTH, 64, number of BHT counters; power of two, at least 2.
- FLUSH_CYCLES, 2, non-stall cycles after a redirect during which in_valid is ignored; 0 disables masking.
- CTR_INIT, 2'b01, reset value of every BHT counter (weakly not-taken).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  execute-stage instruction valid
- op  in  bj_op_t(4)  NONE/JAL/JALR/BEQ/BNE/BLT/BGE/BLTU/BGEU
- stall  in  1  execute stalled
- pc  in  XLEN  instruction PC
- data1  in  XLEN  rs1 value (JALR base)
- imm  in  XLEN  sign-extended immediate
- flag  in  1  ALU compare result bit 0
- pred_taken  in  1  prediction carried from fetch
- pred_pc  in  XLEN  predicted next PC carried from fetch
- fetch_pc  in  XLEN  BHT lookup PC
- fetch_pred_taken  out  1  MSB of the BHT counter for fetch_pc
- redirect_en  out  1  one-cycle redirect pulse
- redirect_pc  out  XLEN  correct next PC
- flushing  out  1  drain window active
- mispredict_cnt  out  32  mispredict counter, wraps
- exc_valid  out  1  misaligned-target exception (optional feature)
- exc_tval  out  XLEN  faulting target

Behaviour:
- Reset: redirect_en=0, redirect_pc=0, flushing=0, drain counter=0, mispredict_cnt=0, exc_valid=0, exc_tval=0, all BHT counters=CTR_INIT. Reset mid-drain clears the drain counter immediately.
- Resolve condition: resolve = in_valid & ~stall & ~flushing & (op!=NONE). A stalled or masked op has no side effects.
- Taken:
  - JAL and JALR: always taken.
  - BEQ/BLT/BLTU: taken when flag=1.
  - BNE/BGE/BGEU: taken when flag=0.
- Target:
  - JAL and branches: pc+imm.
  - JALR: (data1+imm) with bit 0 cleared.
  - All sums are modulo 2^XLEN.
- Next PC: actual = taken ? target : pc+4.
- Mispredict:
  - Conditional branch: (pred_taken != taken) OR (taken & pred_pc != target).
  - JAL/JALR: ~pred_taken OR pred_pc != target.
- Redirect: latency is 1 cycle.
  - Mispredict at edge N gives redirect_en=1 and redirect_pc=actual during cycle N+1 only.
  - mispredict_cnt increments at the same edge.
  - The drain counter loads FLUSH_CYCLES at that edge.
- Drain:
  - flushing = (drain counter != 0).
  - The counter decrements on each cycle with ~stall and holds while stalled.
  - A redirect cannot occur while flushing.
- BHT:
  - Index = pc[log2(BHT_DEPTH)+1:2]; fetch uses the same slice of fetch_pc.
  - Trained on resolved conditional branches only: taken increments, not-taken decrements, saturating at 3 and 0. Write occurs at the resolve edge.
  - Read is combinational. A same-cycle read and write of one index returns the old value.

Optional Feature:
- Macro: BJ_MISALIGN_EXC_EN.
- Defined: a resolved taken op with target[1]=1 raises exc_valid for one cycle with exc_tval=target, same latency as redirect. The redirect is suppressed and mispredict_cnt is unchanged; BHT training still occurs. The drain counter loads FLUSH_CYCLES.
- Undefined: exc_valid and exc_tval are tied to 0 and targets are not checked.

Decomposition:
- Package bj_pkg: bj_op_t enum; ctr_t (2-bit); constants CTR_SNT/WNT/WT/ST; function bj_taken(op, flag); function ctr_next(ctr, taken).
- Sub-module bj_bht: the counter array with one combinational read port, one write port and synchronous reset.
- bj_resolve contains the resolve logic, registers, drain counter and perf counter.

Test Plan:
- BEQ, pc=0x1000, imm=0x40, flag=1, pred_taken=0 -> next cycle redirect_en=1 and redirect_pc=0x1040; mispredict_cnt=1; flushing for 2 cycles.
- BNE, flag=1, pred_taken=0 -> no redirect; BHT[idx(0x1000)] decrements 01->00; fetch_pred_taken=0.
- JALR, data1=0x2003, imm=0x4, pred_taken=1, pred_pc=0x2006 -> target 0x2006; no redirect. Then pred_pc=0x2008 -> redirect_pc=0x2006.
- Mispredict, then in_valid with a mispredicting op during the drain (stall asserted one cycle) -> ignored; flushing lasts 3 cycles; exactly one redirect.
- BLT taken three times at one PC -> counter 01->10->11->11 (saturates); fetch_pred_taken=1. Assert rst -> counter returns to 01.
- With BJ_MISALIGN_EXC_EN: JAL, pc=0x100, imm=0x2 -> exc_valid=1, exc_tval=0x102, redirect_en=0.
